regfile_bypass_param: RTL and testbench

- Parametrised register file for the pipelined CPU: two read ports, one write port, all synchronous to the rising clock edge.
- Generalises width and depth over the fixed 16x16 file.
- Adds internal write-to-read bypass, a hardware clear sequencer (after reset and on demand), and a busy flag the decode stage uses to stall.
- Entry 0 is hardwired to zero.

---
 rtl/regfile_bypass_param.sv | 120 ++++++++++++
 tb/tb_regfile_bypass_param.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass_param.sv
// Parametrised 2R1W register file with write-to-read bypass,
// hardware clear sweep and a busy flag for decode stalls.
module regfile_bypass_param #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    p0_addr,
    input  logic [AW-1:0]    p1_addr,
    input  logic             re0,
    input  logic             re1,
    input  logic [AW-1:0]    dst_addr,
    input  logic [WIDTH-1:0] dst,
    input  logic             we,
    input  logic             clr,
    input  logic             hlt,
    output logic [WIDTH-1:0] p0,
    output logic [WIDTH-1:0] p1,
    output logic             busy
);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    state_t           state;
    logic [AW-1:0]    clr_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic [WIDTH-1:0] rd0;
    logic [WIDTH-1:0] rd1;

    // clr wins over a write presented in the same cycle
    assign wr_en = (state == RUN) && we && !clr && (dst_addr != '0);

    always_comb begin
        rd0 = '0;
        rd1 = '0;
        if (p0_addr != '0 && state == RUN) begin
            if (we && dst_addr == p0_addr) rd0 = dst;
            else                           rd0 = mem[p0_addr];
        end
        if (p1_addr != '0 && state == RUN) begin
            if (we && dst_addr == p1_addr) rd1 = dst;
            else                           rd1 = mem[p1_addr];
        end
    end

    // entry 0 is never written; reads of it are forced to zero
    always_ff @(posedge clk) begin
        if (state == CLEAR) mem[clr_ptr] <= '0;
        else if (wr_en)     mem[dst_addr] <= dst;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= ONE;
            busy    <= 1'b1;
        end else begin
            unique case (state)
                CLEAR: begin
                    if (clr) begin
                        clr_ptr <= ONE;
                    end else if (clr_ptr == LAST) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + ONE;
                    end
                end
                RUN: begin
                    if (clr) begin
                        state   <= CLEAR;
                        clr_ptr <= ONE;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= ONE;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0 <= '0;
            p1 <= '0;
        end else begin
            if (re0) p0 <= rd0;
            if (re1) p1 <= rd1;
        end
    end

`ifndef SYNTHESIS
    logic hlt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hlt_q <= 1'b0;
        else        hlt_q <= hlt;
    end

    always @(posedge clk) begin
        if (hlt && !hlt_q) begin
            for (int i = 1; i < DEPTH; i++)
                $display("R%h = %h", AW'(i), mem[i]);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_bypass_param.sv
// Randomised self-checking bench for regfile_bypass_param,
// covering a 16x16 and a 32x32 instance.
module tb_regfile_bypass_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  p0_addr, p1_addr, dst_addr;
    logic        re0, re1, we, clr, hlt;
    logic [15:0] dst, p0, p1;
    logic        busy;

    logic [4:0]  w_p0_addr, w_p1_addr, w_dst_addr;
    logic        w_re0, w_re1, w_we, w_clr;
    logic [31:0] w_dst, w_p0, w_p1;
    logic        w_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] model [16];
    logic [15:0] exp_p0, exp_p1;

    always #5 clk = ~clk;

    regfile_bypass_param u_dut (
        .clk(clk), .rst_n(rst_n),
        .p0_addr(p0_addr), .p1_addr(p1_addr),
        .re0(re0), .re1(re1),
        .dst_addr(dst_addr), .dst(dst), .we(we),
        .clr(clr), .hlt(hlt),
        .p0(p0), .p1(p1), .busy(busy)
    );

    regfile_bypass_param #(.WIDTH(32), .DEPTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .p0_addr(w_p0_addr), .p1_addr(w_p1_addr),
        .re0(w_re0), .re1(w_re1),
        .dst_addr(w_dst_addr), .dst(w_dst), .we(w_we),
        .clr(w_clr), .hlt(hlt),
        .p0(w_p0), .p1(w_p1), .busy(w_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        re0 = 0; re1 = 0; we = 0; clr = 0;
        w_re0 = 0; w_re1 = 0; w_we = 0; w_clr = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model[i] = '0;
    endtask

    function automatic logic [15:0] model_rd(
        input logic [3:0] a, input logic w,
        input logic [3:0] da, input logic [15:0] d);
        if (a == 0) return '0;
        if (w && da == a) return d;
        return model[a];
    endfunction

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        idle();
        hlt = 0;
        p0_addr = 0; p1_addr = 0; dst_addr = 0; dst = 0;
        w_p0_addr = 0; w_p1_addr = 0; w_dst_addr = 0; w_dst = 0;
        rst_n = 0;
        #12;
        n_checks++;
        if (p0 !== 16'h0 || p1 !== 16'h0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: p0=%h p1=%h busy=%b, want 0 0 1",
                     p0, p1, busy);
        end
        tick();
        rst_n = 1;
        count_busy(n);
        n_checks++;
        if (n != 15) begin
            n_fail++;
            $display("FAIL reset_busy_len: got %0d cycles, want 15", n);
        end
        model_clear();
        re0 = 1; p0_addr = 5;
        tick();
        re0 = 0;
        n_checks++;
        if (p0 !== 16'h0) begin
            n_fail++;
            $display("FAIL read_after_clear: p0=%h want 0000", p0);
        end
        exp_p0 = 0; exp_p1 = 0;
    endtask

    task automatic test_bypass();
        we = 1; dst_addr = 3; dst = 16'hBEEF;
        re0 = 1; p0_addr = 3;
        tick();
        model[3] = 16'hBEEF;
        n_checks++;
        if (p0 !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL bypass: p0=%h want beef", p0);
        end
        we = 0;
        tick();
        re0 = 0;
        n_checks++;
        if (p0 !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL readback: p0=%h want beef", p0);
        end
        exp_p0 = 16'hBEEF;
    endtask

    task automatic test_zero_write();
        we = 1; dst_addr = 0; dst = 16'h1234;
        re0 = 1; re1 = 1; p0_addr = 0; p1_addr = 0;
        tick();
        we = 0;
        tick();
        re0 = 0; re1 = 0;
        n_checks++;
        if (p0 !== 16'h0 || p1 !== 16'h0) begin
            n_fail++;
            $display("FAIL zero_reg: p0=%h p1=%h want 0000", p0, p1);
        end
        exp_p0 = 0; exp_p1 = 0;
    endtask

    task automatic test_hold();
        re1 = 1; p1_addr = 3;
        tick();
        re1 = 0;
        we = 1; dst_addr = 7; dst = 16'h00AA; p1_addr = 7;
        tick();
        model[7] = 16'h00AA;
        we = 0;
        tick();
        n_checks++;
        if (p1 !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL hold: p1=%h want beef", p1);
        end
        re1 = 1;
        tick();
        re1 = 0;
        n_checks++;
        if (p1 !== 16'h00AA) begin
            n_fail++;
            $display("FAIL hold_release: p1=%h want 00aa", p1);
        end
        exp_p1 = 16'h00AA;
    endtask

    task automatic test_random();
        logic [3:0]  a0, a1, da;
        logic [15:0] d;
        logic        w, r0, r1;
        for (int i = 0; i < 300; i++) begin
            a0 = 4'($urandom); a1 = 4'($urandom);
            da = 4'($urandom); d = 16'($urandom);
            w  = 1'($urandom); r0 = 1'($urandom); r1 = 1'($urandom);
            if (i % 4 == 0) a0 = da;
            p0_addr = a0; p1_addr = a1; dst_addr = da; dst = d;
            we = w; re0 = r0; re1 = r1;
            if (r0) exp_p0 = model_rd(a0, w, da, d);
            if (r1) exp_p1 = model_rd(a1, w, da, d);
            if (w && da != 0) model[da] = d;
            tick();
            n_checks++;
            if (p0 !== exp_p0 || p1 !== exp_p1) begin
                n_fail++;
                $display("FAIL random[%0d]: p0=%h p1=%h want %h %h",
                         i, p0, p1, exp_p0, exp_p1);
            end
        end
        idle();
    endtask

    task automatic test_clear();
        int n;
        we = 1; dst_addr = 7; dst = 16'h00AA;
        tick();
        we = 1; dst_addr = 2; dst = 16'h5555; clr = 1;
        tick();
        idle();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_busy: busy=%b want 1", busy);
        end
        re1 = 1; p1_addr = 7;
        tick();
        re1 = 0;
        n_checks++;
        if (p1 !== 16'h0) begin
            n_fail++;
            $display("FAIL read_in_clear: p1=%h want 0000", p1);
        end
        count_busy(n);
        n++;
        n_checks++;
        if (n != 15) begin
            n_fail++;
            $display("FAIL clr_busy_len: got %0d cycles, want 15", n);
        end
        model_clear();
        re0 = 1; p0_addr = 7; re1 = 1; p1_addr = 2;
        tick();
        idle();
        n_checks++;
        if (p0 !== 16'h0 || p1 !== 16'h0) begin
            n_fail++;
            $display("FAIL after_clr: R7=%h R2=%h want 0000", p0, p1);
        end
        exp_p0 = 0; exp_p1 = 0;
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        we = 1; dst_addr = 4; dst = 16'h1111;
        re0 = 1; p0_addr = 4; re1 = 1; p1_addr = 4;
        tick();
        idle();
        clr = 1;
        tick();
        clr = 0;
        repeat (5) tick();
        n_checks++;
        if (p0 !== 16'h1111 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_hold: p0=%h busy=%b want 1111 1",
                     p0, busy);
        end
        #2 rst_n = 0;
        #1;
        n_checks++;
        if (p0 !== 16'h0 || p1 !== 16'h0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: p0=%h p1=%h busy=%b want 0 0 1",
                     p0, p1, busy);
        end
        tick();
        rst_n = 1;
        count_busy(n);
        n_checks++;
        if (n != 15) begin
            n_fail++;
            $display("FAIL rst_busy_len: got %0d cycles, want 15", n);
        end
        model_clear();
        exp_p0 = 0; exp_p1 = 0;
    endtask

    task automatic test_wide();
        int n;
        idle();
        rst_n = 0;
        #12;
        tick();
        rst_n = 1;
        n = 0;
        while (w_busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        n_checks++;
        if (n != 31) begin
            n_fail++;
            $display("FAIL wide_busy_len: got %0d cycles, want 31", n);
        end
        w_we = 1; w_dst_addr = 9; w_dst = 32'hDEADBEEF;
        w_re0 = 1; w_p0_addr = 9; w_re1 = 1; w_p1_addr = 9;
        tick();
        n_checks++;
        if (w_p0 !== 32'hDEADBEEF || w_p1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wide_bypass: p0=%h p1=%h want deadbeef",
                     w_p0, w_p1);
        end
        w_we = 0; w_p1_addr = 31;
        tick();
        idle();
        n_checks++;
        if (w_p0 !== 32'hDEADBEEF || w_p1 !== 32'h0) begin
            n_fail++;
            $display("FAIL wide_read: p0=%h p1=%h want deadbeef 0",
                     w_p0, w_p1);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_write();
        test_hold();
        test_random();
        test_clear();
        test_random();
        test_reset_mid_sweep();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
